// File: rtl/sha_pkg.sv
// Shared SHA definitions: mode/message types, schedule state enum, round counts
// and the sigma/rotate helpers used by the message-schedule expansion.
package sha;

  typedef enum logic [2:0] {
    mode_sha1       = 3'd0,
    mode_sha224     = 3'd1,
    mode_sha256     = 3'd2,
    mode_sha384     = 3'd3,
    mode_sha512     = 3'd4,
    mode_sha512_224 = 3'd5,
    mode_sha512_256 = 3'd6,
    mode_rsvd       = 3'd7
  } mode_t;

  // w32 aliases the low 512 bits: w32[15] is the first 32-bit word of a 512-bit block
  typedef union packed {
    logic [15:0][63:0] w64;
    logic [31:0][31:0] w32;
  } msg_t;

  typedef logic [15:0][63:0] window_t;

  typedef enum logic {st_idle, st_run} sched_state_t;

  localparam int unsigned rounds_64 = 64;
  localparam int unsigned rounds_80 = 80;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] delta0_32(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] delta1_32(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [63:0] delta0_64(input logic [63:0] x);
    return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] delta1_64(input logic [63:0] x);
    return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
  endfunction

  function automatic logic is_512(input mode_t m);
    return (m == mode_sha384) || (m == mode_sha512) ||
           (m == mode_sha512_224) || (m == mode_sha512_256);
  endfunction

  // window entry 0 holds W[t]; the returned word is W[t+16]
  function automatic logic [31:0] next_w_sha1(input window_t s);
    return rotl1(s[13][31:0] ^ s[8][31:0] ^ s[2][31:0] ^ s[0][31:0]);
  endfunction

  function automatic logic [31:0] next_w32(input window_t s);
    return delta1_32(s[14][31:0]) + s[9][31:0] + delta0_32(s[1][31:0]) + s[0][31:0];
  endfunction

  function automatic logic [63:0] next_w64(input window_t s);
    return delta1_64(s[14]) + s[9] + delta0_64(s[1]) + s[0];
  endfunction

endpackage

// File: rtl/sha_msg_schedule.sv
// SHA-1/SHA-2 message schedule: expands one 1024-bit block into W_t words.
// SHA-1 support is compiled in only when SHA_SCHED_SHA1_EN is defined.
module sha_msg_schedule
  import sha::*;
(
  input  logic        clk,
  input  logic        rst,
  input  mode_t       mode,
  input  msg_t        blk,
  input  logic        blk_valid,
  output logic        blk_ready,
  output logic [63:0] w,
  output logic [6:0]  w_idx,
  output logic        w_valid,
  input  logic        w_ready,
  output logic        w_last,
  output logic        err
);

  sched_state_t state, state_nxt;
  mode_t        mode_q;
  window_t      win;
  logic [6:0]   idx;
  logic         err_q;
  logic         mode_ok;
  logic         accept;
  logic         hs;
  logic [6:0]   last_idx;
  logic [63:0]  nw;

  always_comb begin
    mode_ok = 1'b0;
    case (mode)
      mode_sha224, mode_sha256, mode_sha384, mode_sha512,
      mode_sha512_224, mode_sha512_256: mode_ok = 1'b1;
`ifdef SHA_SCHED_SHA1_EN
      mode_sha1: mode_ok = 1'b1;
`endif
      default: mode_ok = 1'b0;
    endcase
  end

  assign last_idx = ((mode_q == mode_sha224) || (mode_q == mode_sha256)) ?
                    7'(rounds_64 - 1) : 7'(rounds_80 - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= st_idle;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    blk_ready = 1'b0;
    w_valid   = 1'b0;
    w_last    = 1'b0;
    case (state)
      st_idle: begin
        blk_ready = 1'b1;
        if (blk_valid && mode_ok) state_nxt = st_run;
      end
      st_run: begin
        w_valid = 1'b1;
        w_last  = (idx == last_idx);
        if (w_ready && w_last) state_nxt = st_idle;
      end
      default: state_nxt = st_idle;
    endcase
  end

  assign accept = blk_valid && blk_ready;
  assign hs     = w_valid && w_ready;

  always_comb begin
    nw = '0;
    if (is_512(mode_q)) nw = next_w64(win);
`ifdef SHA_SCHED_SHA1_EN
    else if (mode_q == mode_sha1) nw = {32'h0, next_w_sha1(win)};
`endif
    else nw = {32'h0, next_w32(win)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= mode_sha1;
      win    <= '0;
      idx    <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept && !mode_ok;
      if (accept) begin
        mode_q <= mode;
        idx    <= '0;
        for (int unsigned j = 0; j < 16; j++)
          win[j] <= is_512(mode) ? blk.w64[15-j] : {32'h0, blk.w32[15-j]};
      end else if (hs) begin
        // entry 0 always presents the current word; new word enters at the top
        idx <= idx + 7'd1;
        for (int unsigned j = 0; j < 15; j++)
          win[j] <= win[j+1];
        win[15] <= nw;
      end
    end
  end

  assign w     = win[0];
  assign w_idx = idx;
  assign err   = err_q;

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Directed bench for sha_msg_schedule; honours SHA_SCHED_SHA1_EN like the design.
module tb_sha_msg_schedule;
  import sha::*;

  logic        clk;
  logic        rst;
  mode_t       mode;
  msg_t        blk;
  logic        blk_valid;
  logic        blk_ready;
  logic [63:0] w;
  logic [6:0]  w_idx;
  logic        w_valid;
  logic        w_ready;
  logic        w_last;
  logic        err;

  int vectors;
  int miscompares;

  logic [63:0] exp_w [0:79];
  logic [63:0] got_w [0:127];
  logic [6:0]  got_idx [0:127];
  logic        got_last [0:127];
  int          n_got;
  int          bubbles;
  int          stall_bad;
  int          stalls;
  bit          timeout;

  msg_t blk256;
  msg_t blk512;

  sha_msg_schedule dut (
    .clk(clk), .rst(rst), .mode(mode), .blk(blk), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .w(w), .w_idx(w_idx), .w_valid(w_valid),
    .w_ready(w_ready), .w_last(w_last), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic build_model(input mode_t m, input msg_t b);
    logic [31:0] a, s0, s1;
    logic [63:0] x, y, S0, S1;
    bit wide;
    wide = (m == mode_sha384) || (m == mode_sha512) ||
           (m == mode_sha512_224) || (m == mode_sha512_256);
    for (int t = 0; t < 16; t++)
      exp_w[t] = wide ? b.w64[15-t] : {32'h0, b.w32[15-t]};
    for (int t = 16; t < 80; t++) begin
      if (m == mode_sha1) begin
        a = exp_w[t-3][31:0] ^ exp_w[t-8][31:0] ^ exp_w[t-14][31:0] ^ exp_w[t-16][31:0];
        exp_w[t] = {32'h0, a[30:0], a[31]};
      end else if (wide) begin
        x  = exp_w[t-15];
        y  = exp_w[t-2];
        S0 = {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
        S1 = {y[18:0], y[63:19]} ^ {y[60:0], y[63:61]} ^ (y >> 6);
        exp_w[t] = S1 + exp_w[t-7] + S0 + exp_w[t-16];
      end else begin
        a  = exp_w[t-15][31:0];
        s0 = {a[6:0], a[31:7]} ^ {a[17:0], a[31:18]} ^ (a >> 3);
        a  = exp_w[t-2][31:0];
        s1 = {a[16:0], a[31:17]} ^ {a[18:0], a[31:19]} ^ (a >> 10);
        exp_w[t] = {32'h0, s1 + exp_w[t-7][31:0] + s0 + exp_w[t-16][31:0]};
      end
    end
  endtask

  task automatic send_block(input mode_t m, input msg_t b);
    @(negedge clk);
    mode = m;
    blk = b;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  // Starts at the negedge after accept; records every handshake until w_last.
  task automatic collect(input bit rnd);
    bit r, done, pstall;
    logic [63:0] pw;
    logic [6:0] pi;
    logic pl;
    n_got = 0; bubbles = 0; stall_bad = 0; stalls = 0; timeout = 0;
    done = 0; pstall = 0; pw = '0; pi = '0; pl = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (pstall && (!w_valid || w !== pw || w_idx !== pi || w_last !== pl)) stall_bad++;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      w_ready = r;
      if (!w_valid && r) bubbles++;
      if (w_valid && !r) stalls++;
      if (w_valid && r && n_got < 128) begin
        got_w[n_got] = w; got_idx[n_got] = w_idx; got_last[n_got] = w_last;
        n_got++;
        if (w_last) done = 1;
      end
      pstall = w_valid && !r; pw = w; pi = w_idx; pl = w_last;
      @(negedge clk);
    end
    w_ready = 1'b0;
    if (!done) timeout = 1;
  endtask

  task automatic test_reset;
    #12;
    vectors++; if (blk_ready !== 1'b1) begin miscompares++; $display("FAIL reset_blk_ready: got %b want 1", blk_ready); end
    vectors++; if (w_valid !== 1'b0) begin miscompares++; $display("FAIL reset_w_valid: got %b want 0", w_valid); end
    vectors++; if (w_last !== 1'b0) begin miscompares++; $display("FAIL reset_w_last: got %b want 0", w_last); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (w !== 64'h0) begin miscompares++; $display("FAIL reset_w: got %h want 0", w); end
    vectors++; if (w_idx !== 7'd0) begin miscompares++; $display("FAIL reset_w_idx: got %0d want 0", w_idx); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sha256;
    build_model(mode_sha256, blk256);
    send_block(mode_sha256, blk256);
    vectors++; if (w_valid !== 1'b1 || w_idx !== 7'd0 || w !== 64'h61626380) begin
      miscompares++; $display("FAIL sha256_first: got v=%b idx=%0d w=%h want v=1 idx=0 w=61626380", w_valid, w_idx, w); end
    collect(0);
    vectors++; if (timeout || n_got != 64) begin miscompares++; $display("FAIL sha256_count: got %0d words want 64", n_got); end
    vectors++; if (got_w[15] !== 64'h18) begin miscompares++; $display("FAIL sha256_w15: got %h want 18", got_w[15]); end
    vectors++; if (got_w[16] !== 64'h61626380) begin miscompares++; $display("FAIL sha256_w16: got %h want 61626380", got_w[16]); end
    vectors++; if (got_w[17] !== 64'h000F0000) begin miscompares++; $display("FAIL sha256_w17: got %h want 000f0000", got_w[17]); end
    for (int i = 0; i < 64 && i < n_got; i++) begin
      vectors++;
      if (got_w[i] !== exp_w[i] || got_idx[i] !== 7'(i) || got_last[i] !== (i == 63)) begin
        miscompares++;
        $display("FAIL sha256_word[%0d]: got w=%h idx=%0d last=%b want w=%h idx=%0d last=%b",
                 i, got_w[i], got_idx[i], got_last[i], exp_w[i], i, (i == 63));
      end
    end
    vectors++; if (blk_ready !== 1'b1 || w_valid !== 1'b0) begin
      miscompares++; $display("FAIL sha256_idle_after: got ready=%b valid=%b want 1 0", blk_ready, w_valid); end
  endtask

  task automatic test_sha512;
    build_model(mode_sha512, blk512);
    send_block(mode_sha512, blk512);
    collect(0);
    vectors++; if (timeout || n_got != 80) begin miscompares++; $display("FAIL sha512_count: got %0d words want 80", n_got); end
    vectors++; if (bubbles != 0) begin miscompares++; $display("FAIL sha512_bubbles: got %0d want 0", bubbles); end
    vectors++; if (got_w[16] !== 64'h6162638000000000) begin miscompares++; $display("FAIL sha512_w16: got %h want 6162638000000000", got_w[16]); end
    for (int i = 0; i < 80 && i < n_got; i++) begin
      vectors++;
      if (got_w[i] !== exp_w[i] || got_idx[i] !== 7'(i) || got_last[i] !== (i == 79)) begin
        miscompares++;
        $display("FAIL sha512_word[%0d]: got w=%h idx=%0d last=%b want w=%h idx=%0d last=%b",
                 i, got_w[i], got_idx[i], got_last[i], exp_w[i], i, (i == 79));
      end
    end
  endtask

  task automatic test_stall;
    build_model(mode_sha256, blk256);
    send_block(mode_sha256, blk256);
    collect(1);
    vectors++; if (timeout || n_got != 64) begin miscompares++; $display("FAIL stall_count: got %0d words want 64", n_got); end
    vectors++; if (stall_bad != 0) begin miscompares++; $display("FAIL stall_hold: got %0d unstable stalls want 0", stall_bad); end
    vectors++; if (stalls == 0) begin miscompares++; $display("FAIL stall_seen: got %0d stall cycles want >0", stalls); end
    for (int i = 0; i < 64 && i < n_got; i++) begin
      vectors++;
      if (got_w[i] !== exp_w[i] || got_idx[i] !== 7'(i) || got_last[i] !== (i == 63)) begin
        miscompares++;
        $display("FAIL stall_word[%0d]: got w=%h idx=%0d want w=%h idx=%0d", i, got_w[i], got_idx[i], exp_w[i], i);
      end
    end
  endtask

  task automatic test_sha1;
    build_model(mode_sha1, blk256);
    send_block(mode_sha1, blk256);
`ifdef SHA_SCHED_SHA1_EN
    collect(0);
    vectors++; if (timeout || n_got != 80) begin miscompares++; $display("FAIL sha1_count: got %0d words want 80", n_got); end
    vectors++; if (got_w[16] !== 64'hC2C4C700) begin miscompares++; $display("FAIL sha1_w16: got %h want c2c4c700", got_w[16]); end
    for (int i = 0; i < 80 && i < n_got; i++) begin
      vectors++;
      if (got_w[i] !== exp_w[i] || got_idx[i] !== 7'(i) || got_last[i] !== (i == 79)) begin
        miscompares++;
        $display("FAIL sha1_word[%0d]: got w=%h idx=%0d last=%b want w=%h idx=%0d last=%b",
                 i, got_w[i], got_idx[i], got_last[i], exp_w[i], i, (i == 79));
      end
    end
`else
    vectors++; if (err !== 1'b1 || w_valid !== 1'b0 || blk_ready !== 1'b1) begin
      miscompares++; $display("FAIL sha1_off_err: got err=%b valid=%b ready=%b want 1 0 1", err, w_valid, blk_ready); end
    @(negedge clk);
    vectors++; if (err !== 1'b0 || w_valid !== 1'b0) begin
      miscompares++; $display("FAIL sha1_off_pulse: got err=%b valid=%b want 0 0", err, w_valid); end
`endif
  endtask

  task automatic test_bad_mode;
    int seen_valid;
    send_block(mode_rsvd, blk256);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL mode7_err: got %b want 1", err); end
    vectors++; if (blk_ready !== 1'b1) begin miscompares++; $display("FAIL mode7_ready: got %b want 1", blk_ready); end
    seen_valid = w_valid ? 1 : 0;
    @(negedge clk);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL mode7_pulse: got %b want 0", err); end
    for (int c = 0; c < 4; c++) begin
      if (w_valid) seen_valid++;
      @(negedge clk);
    end
    vectors++; if (seen_valid != 0) begin miscompares++; $display("FAIL mode7_no_valid: got %0d valid cycles want 0", seen_valid); end
  endtask

  task automatic test_reset_mid;
    bit reached;
    build_model(mode_sha256, blk256);
    send_block(mode_sha256, blk256);
    reached = 0;
    for (int c = 0; c < 100; c++) begin
      if (w_valid && w_idx == 7'd20) begin reached = 1; break; end
      w_ready = 1'b1;
      @(negedge clk);
    end
    w_ready = 1'b0;
    vectors++; if (!reached) begin miscompares++; $display("FAIL rstmid_reach: got idx %0d want 20", w_idx); end
    rst = 1'b1;
    #1;
    vectors++; if (w_valid !== 1'b0 || blk_ready !== 1'b1 || w_idx !== 7'd0) begin
      miscompares++; $display("FAIL rstmid_abort: got valid=%b ready=%b idx=%0d want 0 1 0", w_valid, blk_ready, w_idx); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (w_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_quiet: got valid=%b want 0", w_valid); end
    build_model(mode_sha512, blk512);
    send_block(mode_sha512, blk512);
    vectors++; if (w_valid !== 1'b1 || w_idx !== 7'd0 || w !== exp_w[0]) begin
      miscompares++; $display("FAIL rstmid_restart: got v=%b idx=%0d w=%h want v=1 idx=0 w=%h", w_valid, w_idx, w, exp_w[0]); end
    collect(0);
    vectors++; if (timeout || n_got != 80 || got_w[79] !== exp_w[79]) begin
      miscompares++; $display("FAIL rstmid_drain: got %0d words last=%h want 80 last=%h", n_got, got_w[79], exp_w[79]); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; mode = mode_sha256; blk = '0; blk_valid = 1'b0; w_ready = 1'b0;
    blk256 = '0; blk256.w32[15] = 32'h61626380; blk256.w32[0] = 32'h18;
    blk512 = '0; blk512.w64[15] = 64'h6162638000000000; blk512.w64[0] = 64'h18;
    test_reset;
    test_sha256;
    test_sha512;
    test_stall;
    test_sha1;
    test_bad_mode;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
